nodf_module_status: RTL and testbench
=====================================

Name: nodf_module_status

Overview:
- Cycle-accurate status tracker for one non-dataflow HLS block-level handshake (ap_start/ap_ready/ap_done/ap_continue).
- Sits beside the DUT top in cosimulation and hardware debug builds.
- Counts transactions, measures per-transaction latency and the ready-to-ready interval, and reports a coarse module state.
- A sampler or dumper reads the outputs; the block never drives the monitored handshake.

Parameters:
- CNT_W, 32, width of cycle and transaction counters.
- DEPTH, 8, number of in-flight start timestamps held (power of two, ≥2).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  1  monitored start.
- ap_ready  in  1  monitored ready (input consumed).
- ap_done  in  1  monitored done.
- ap_continue  in  1  monitored continue; tie 1 when unused.
- finish  in  1  end of simulation/run request.
- state  out  2  0=IDLE, 1=ACTIVE, 2=STALL, 3=FINISHED.
- ready_cnt  out  CNT_W  accepted transactions.
- done_cnt  out  CNT_W  completed transactions.
- in_flight  out  $clog2(DEPTH)+1  ready_cnt minus done_cnt, tracked by the FIFO.
- latency_last  out  CNT_W  start-to-done cycles of the last completed transaction.
- interval_last  out  CNT_W  cycles between the last two ready events.
- stall_cycles  out  CNT_W  cycles with ap_done=1 and ap_continue=0.
- ready_evt  out  1  registered one-cycle pulse for each ready event.
- done_evt  out  1  registered one-cycle pulse for each done event.
- overflow  out  1  sticky flag: timestamp FIFO overflow.
- underflow  out  1  sticky flag: done event with no timestamp.

Behaviour:
- Reset (reset=0, asynchronous): all outputs, counters, the FIFO and the holding register go to 0; state=IDLE.
- cyc: free-running CNT_W counter, +1 per clock, wraps modulo 2^CNT_W.
- Start event:
  - Condition: ap_start=1 while no start is pending.
  - Effect: latch cyc into start_ts and set pending.
- Ready event:
  - Condition: ap_start & ap_ready.
  - Effects: ready_cnt+1; push the timestamp (start_ts, or cyc if the start event occurs in the same cycle) into the FIFO; clear pending.
  - interval_last = cyc − last_ready_cyc. The first ready after reset leaves interval_last=0.
- Done event:
  - Condition: ap_done & ap_continue.
  - Effects: done_cnt+1; pop the FIFO; latency_last = cyc − popped timestamp.
- Same-cycle push and pop: both occur.
  - If the FIFO was empty, the pushed value bypasses to the pop, so latency is 0 for start, ready and done in one cycle.
- FIFO full on push, without a simultaneous pop: drop the timestamp, set overflow; ready_cnt still increments.
- Done with the FIFO empty and no bypass: latency_last holds its value, set underflow; done_cnt still increments.
- Stall: ap_done & ~ap_continue gives stall_cycles+1.
- Arithmetic: all counters and differences are unsigned, modulo 2^CNT_W.
- State, registered, evaluated each cycle from the post-update values:
  - FINISHED if finish has ever been sampled as 1 (sticky until reset).
  - Else STALL if ap_done & ~ap_continue.
  - Else ACTIVE if pending | ap_start | in_flight≠0.
  - Else IDLE.
- FINISHED freezes all counters, latency_last, interval_last and the flags.
  - Event pulses are forced 0; only reset leaves FINISHED.
- Output latency: outputs and pulses update one clock after the sampling edge; no combinational paths from inputs to outputs.
- Reset asserted mid-transaction: all tracking is discarded; no partial-transaction reporting.

Decomposition:
- Shared package nodf_status_pkg holds the state enum (IDLE/ACTIVE/STALL/FINISHED) and the default CNT_W/DEPTH constants.
- One sub-module, nodf_ts_fifo:
  - parameterised width/depth synchronous FIFO;
  - push/pop/bypass, full/empty, count;
  - asynchronous active-low reset.

Test Plan:
- Reset then idle 10 cycles → state=IDLE, all counters 0, no pulses.
- Start at cycle 5, ap_ready at cycle 5, ap_done at cycle 12 (continue=1) → ready_cnt=1, done_cnt=1, latency_last=7, state returns to IDLE.
- Three back-to-back ready events at cycles 10, 14, 18 with done events at 20, 24, 28 → interval_last=4, latency_last=10 each, peak in_flight=3.
- ap_done held 5 cycles with ap_continue=0, then continue=1 → state=STALL for those 5 cycles, stall_cycles=5, done_cnt+1 once.
- DEPTH+1 ready events with no done → overflow=1, ready_cnt=DEPTH+1, in_flight=DEPTH; done with an empty FIFO → underflow=1.
- finish=1 during ACTIVE, then further handshakes → state=FINISHED, counters frozen; reset low → all 0, IDLE.

Source files
------------

// File: rtl/nodf_status_pkg.sv
// Shared types and defaults for the non-dataflow handshake status tracker.
package nodf_status_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_STALL    = 2'd2,
    ST_FINISHED = 2'd3
  } mod_state_t;

  // Priority decode of the coarse module state: finished beats stall beats busy.
  function automatic mod_state_t status_decode(input logic finished,
                                               input logic stalled,
                                               input logic busy);
    if (finished)     return ST_FINISHED;
    else if (stalled) return ST_STALL;
    else if (busy)    return ST_ACTIVE;
    else              return ST_IDLE;
  endfunction

endpackage

// File: rtl/nodf_ts_fifo.sv
// Small timestamp FIFO with same-cycle bypass: when empty, a simultaneous
// push and pop hand the pushed word straight to the pop side without storing it.
module nodf_ts_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic bypass;
  logic pop_ok;
  logic push_ok;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == CW'(DEPTH));
  assign bypass = push & pop & empty;
  assign pop_ok = pop & ~empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push_ok = push & ~bypass & (~full | pop_ok);

  assign pop_data   = bypass ? push_data : mem_reg[rd_ptr_reg];
  assign count      = count_reg;
  assign count_next = count_reg + CW'(push_ok) - CW'(pop_ok);

  // Storage array; every slot clears on reset so no stale timestamp survives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/nodf_module_status.sv
// Passive status tracker for one ap_start/ap_ready/ap_done/ap_continue
// handshake: transaction counts, latency, ready interval, stall cycles, state.
module nodf_module_status
  import nodf_status_pkg::*;
#(
  parameter  int CNT_W = DEF_CNT_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int IFW   = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] ready_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [IFW-1:0]   in_flight,
  output logic [CNT_W-1:0] latency_last,
  output logic [CNT_W-1:0] interval_last,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             ready_evt,
  output logic             done_evt,
  output logic             overflow,
  output logic             underflow
);

  logic [CNT_W-1:0] cyc_reg;
  logic             pending_reg, pending_next;
  logic [CNT_W-1:0] start_ts_reg, start_ts_next;
  logic [CNT_W-1:0] last_ready_reg, last_ready_next;
  logic             seen_ready_reg, seen_ready_next;
  logic             finished_reg, finished_next;
  logic [CNT_W-1:0] ready_cnt_reg, ready_cnt_next;
  logic [CNT_W-1:0] done_cnt_reg, done_cnt_next;
  logic [CNT_W-1:0] latency_reg, latency_next;
  logic [CNT_W-1:0] interval_reg, interval_next;
  logic [CNT_W-1:0] stall_reg, stall_next;
  logic             ready_evt_reg, done_evt_reg;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  mod_state_t       state_reg, state_next;

  logic             run;
  logic             start_evt;
  logic             rdy_evt;
  logic             dn_evt;
  logic             stl_evt;
  logic [CNT_W-1:0] push_ts;
  logic [CNT_W-1:0] pop_ts;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IFW-1:0]   fifo_count;
  logic [IFW-1:0]   fifo_count_next;

  // Once finish is seen (including the cycle it is first sampled) all tracking freezes.
  assign run       = ~finished_reg & ~finish;
  assign start_evt = run & ap_start & ~pending_reg;
  assign rdy_evt   = run & ap_start & ap_ready;
  assign dn_evt    = run & ap_done & ap_continue;
  assign stl_evt   = run & ap_done & ~ap_continue;
  // A start and ready in the same cycle stamp the current cycle directly.
  assign push_ts   = pending_reg ? start_ts_reg : cyc_reg;

  nodf_ts_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (DEPTH)
  ) u_ts_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (rdy_evt),
    .push_data  (push_ts),
    .pop        (dn_evt),
    .pop_data   (pop_ts),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  // Next-state for all tracking registers; defaults hold the current value.
  always_comb begin
    pending_next    = pending_reg;
    start_ts_next   = start_ts_reg;
    last_ready_next = last_ready_reg;
    seen_ready_next = seen_ready_reg;
    ready_cnt_next  = ready_cnt_reg;
    done_cnt_next   = done_cnt_reg;
    latency_next    = latency_reg;
    interval_next   = interval_reg;
    stall_next      = stall_reg;
    overflow_next   = overflow_reg;
    underflow_next  = underflow_reg;
    finished_next   = finished_reg | finish;

    if (start_evt) begin
      pending_next  = 1'b1;
      start_ts_next = cyc_reg;
    end

    if (rdy_evt) begin
      pending_next    = 1'b0;
      ready_cnt_next  = ready_cnt_reg + CNT_W'(1);
      seen_ready_next = 1'b1;
      last_ready_next = cyc_reg;
      if (seen_ready_reg) interval_next = cyc_reg - last_ready_reg;
      if (fifo_full && !dn_evt) overflow_next = 1'b1;
    end

    if (dn_evt) begin
      done_cnt_next = done_cnt_reg + CNT_W'(1);
      // An empty FIFO still yields a timestamp when a push bypasses to the pop.
      if (fifo_empty && !rdy_evt) underflow_next = 1'b1;
      else                        latency_next   = cyc_reg - pop_ts;
    end

    if (stl_evt) stall_next = stall_reg + CNT_W'(1);

    state_next = status_decode(finished_next,
                               ap_done & ~ap_continue,
                               pending_next | ap_start | (fifo_count_next != '0));
  end

  // Free-running cycle stamp, wraps modulo 2^CNT_W.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cyc_reg <= '0;
    else        cyc_reg <= cyc_reg + CNT_W'(1);
  end

  // Pending-start and last-ready bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_reg    <= 1'b0;
      start_ts_reg   <= '0;
      last_ready_reg <= '0;
      seen_ready_reg <= 1'b0;
      finished_reg   <= 1'b0;
    end else begin
      pending_reg    <= pending_next;
      start_ts_reg   <= start_ts_next;
      last_ready_reg <= last_ready_next;
      seen_ready_reg <= seen_ready_next;
      finished_reg   <= finished_next;
    end
  end

  // Reported counters, measurements, flags, pulses and state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_cnt_reg <= '0;
      done_cnt_reg  <= '0;
      latency_reg   <= '0;
      interval_reg  <= '0;
      stall_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      ready_evt_reg <= 1'b0;
      done_evt_reg  <= 1'b0;
      state_reg     <= ST_IDLE;
    end else begin
      ready_cnt_reg <= ready_cnt_next;
      done_cnt_reg  <= done_cnt_next;
      latency_reg   <= latency_next;
      interval_reg  <= interval_next;
      stall_reg     <= stall_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      ready_evt_reg <= rdy_evt;
      done_evt_reg  <= dn_evt;
      state_reg     <= state_next;
    end
  end

  assign state         = state_reg;
  assign ready_cnt     = ready_cnt_reg;
  assign done_cnt      = done_cnt_reg;
  assign in_flight     = fifo_count;
  assign latency_last  = latency_reg;
  assign interval_last = interval_reg;
  assign stall_cycles  = stall_reg;
  assign ready_evt     = ready_evt_reg;
  assign done_evt      = done_evt_reg;
  assign overflow      = overflow_reg;
  assign underflow     = underflow_reg;

endmodule

// File: tb/tb_nodf_module_status.sv
// Directed bench for nodf_module_status with hand-computed expectations.
module tb_nodf_module_status;

  localparam int CNT_W = 32;
  localparam int DEPTH = 8;
  localparam int IFW   = $clog2(DEPTH) + 1;

  localparam int S_IDLE     = 0;
  localparam int S_ACTIVE   = 1;
  localparam int S_STALL    = 2;
  localparam int S_FINISHED = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             ap_start = 1'b0;
  logic             ap_ready = 1'b0;
  logic             ap_done = 1'b0;
  logic             ap_continue = 1'b1;
  logic             finish = 1'b0;
  logic [1:0]       state;
  logic [CNT_W-1:0] ready_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic [IFW-1:0]   in_flight;
  logic [CNT_W-1:0] latency_last;
  logic [CNT_W-1:0] interval_last;
  logic [CNT_W-1:0] stall_cycles;
  logic             ready_evt;
  logic             done_evt;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_fail   = 0;

  nodf_module_status #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .ap_start      (ap_start),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .ap_continue   (ap_continue),
    .finish        (finish),
    .state         (state),
    .ready_cnt     (ready_cnt),
    .done_cnt      (done_cnt),
    .in_flight     (in_flight),
    .latency_last  (latency_last),
    .interval_last (interval_last),
    .stall_cycles  (stall_cycles),
    .ready_evt     (ready_evt),
    .done_evt      (done_evt),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of handshake inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic s, input logic r, input logic d, input logic c);
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c;
    @(posedge clock); #1;
    if (s | r | d)
      $display("t=%0t start=%b ready=%b done=%b cont=%b -> state=%0d ready_cnt=%0d done_cnt=%0d in_flight=%0d lat=%0d int=%0d",
               $time, s, r, d, c, state, ready_cnt, done_cnt, in_flight, latency_last, interval_last);
  endtask

  initial begin
    // Reset, then idle
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (10) drive(0, 0, 0, 1);
    chk("idle_state", 32'(state), S_IDLE);
    chk("idle_ready_cnt", ready_cnt, 0);
    chk("idle_done_cnt", done_cnt, 0);
    chk("idle_in_flight", 32'(in_flight), 0);
    chk("idle_latency", latency_last, 0);
    chk("idle_interval", interval_last, 0);
    chk("idle_stall", stall_cycles, 0);
    chk("idle_ready_evt", 32'(ready_evt), 0);
    chk("idle_done_evt", 32'(done_evt), 0);
    chk("idle_overflow", 32'(overflow), 0);
    chk("idle_underflow", 32'(underflow), 0);

    // Single transaction: start+ready together, done 7 cycles later
    drive(1, 1, 0, 1);
    chk("t1_ready_evt", 32'(ready_evt), 1);
    chk("t1_ready_cnt", ready_cnt, 1);
    chk("t1_in_flight", 32'(in_flight), 1);
    chk("t1_state_active", 32'(state), S_ACTIVE);
    repeat (6) drive(0, 0, 0, 1);
    chk("t1_ready_evt_gone", 32'(ready_evt), 0);
    chk("t1_state_wait", 32'(state), S_ACTIVE);
    drive(0, 0, 1, 1);
    chk("t1_done_evt", 32'(done_evt), 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_latency", latency_last, 7);
    chk("t1_in_flight_end", 32'(in_flight), 0);
    chk("t1_state_idle", 32'(state), S_IDLE);
    chk("t1_interval_first", interval_last, 0);

    // Bypass: start, ready and done in one cycle (8 cycles after previous ready)
    drive(1, 1, 1, 1);
    chk("byp_latency", latency_last, 0);
    chk("byp_ready_cnt", ready_cnt, 2);
    chk("byp_done_cnt", done_cnt, 2);
    chk("byp_in_flight", 32'(in_flight), 0);
    chk("byp_interval", interval_last, 8);
    chk("byp_state", 32'(state), S_ACTIVE);
    chk("byp_underflow", 32'(underflow), 0);
    drive(0, 0, 0, 1);
    chk("byp_state_idle", 32'(state), S_IDLE);

    // Start held two cycles before ready; latency measured from the start
    drive(1, 0, 0, 1);
    chk("pend_state", 32'(state), S_ACTIVE);
    chk("pend_in_flight", 32'(in_flight), 0);
    drive(1, 0, 0, 1);
    drive(1, 1, 0, 1);
    chk("pend_ready_cnt", ready_cnt, 3);
    chk("pend_interval", interval_last, 4);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    chk("pend_latency", latency_last, 4);

    // Three overlapped transactions: readys every 4 cycles, dones 10 after each
    for (int i = 0; i < 19; i++) begin
      drive(i == 0 || i == 4 || i == 8, i == 0 || i == 4 || i == 8,
            i == 10 || i == 14 || i == 18, 1);
      if (i == 4 || i == 8) chk("ovl_interval", interval_last, 4);
      if (i == 8) chk("ovl_peak_in_flight", 32'(in_flight), 3);
      if (i == 10 || i == 14 || i == 18) chk("ovl_latency", latency_last, 10);
    end
    chk("ovl_ready_cnt", ready_cnt, 6);
    chk("ovl_done_cnt", done_cnt, 6);
    chk("ovl_in_flight_end", 32'(in_flight), 0);

    // Stall: done held 5 cycles without continue
    drive(1, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0);
      chk("stall_state", 32'(state), S_STALL);
    end
    chk("stall_cycles", stall_cycles, 5);
    chk("stall_done_cnt_held", done_cnt, 6);
    drive(0, 0, 1, 1);
    chk("stall_done_cnt", done_cnt, 7);
    chk("stall_latency", latency_last, 6);
    chk("stall_state_idle", 32'(state), S_IDLE);
    chk("stall_cycles_final", stall_cycles, 5);

    // Asynchronous reset mid-cycle, no clock edge in between
    reset = 1'b0;
    #2;
    chk("areset_ready_cnt", ready_cnt, 0);
    chk("areset_done_cnt", done_cnt, 0);
    chk("areset_stall", stall_cycles, 0);
    @(posedge clock); #1 reset = 1'b1;

    // Overflow: DEPTH+1 readys without done
    for (int i = 0; i <= DEPTH; i++) begin
      drive(1, 1, 0, 1);
      if (i == 0) chk("ovf_interval_first", interval_last, 0);
      if (i == DEPTH - 1) chk("ovf_not_yet", 32'(overflow), 0);
    end
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_ready_cnt", ready_cnt, DEPTH + 1);
    chk("ovf_in_flight", 32'(in_flight), DEPTH);
    chk("ovf_interval", interval_last, 1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 1, 1);
      chk("drain_latency", latency_last, 9);
    end
    chk("drain_in_flight", 32'(in_flight), 0);
    chk("drain_underflow", 32'(underflow), 0);
    drive(0, 0, 1, 1);
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_latency_held", latency_last, 9);
    chk("udf_done_cnt", done_cnt, DEPTH + 1);
    chk("udf_done_evt", 32'(done_evt), 1);

    // Finish during an active start, then further handshakes are ignored
    drive(1, 0, 0, 1);
    chk("fin_pre_state", 32'(state), S_ACTIVE);
    finish = 1'b1;
    drive(1, 0, 0, 1);
    finish = 1'b0;
    chk("fin_state", 32'(state), S_FINISHED);
    drive(1, 1, 0, 1);
    chk("fin_ready_cnt", ready_cnt, DEPTH + 1);
    chk("fin_ready_evt", 32'(ready_evt), 0);
    drive(0, 0, 1, 1);
    chk("fin_done_cnt", done_cnt, DEPTH + 1);
    chk("fin_done_evt", 32'(done_evt), 0);
    drive(0, 0, 1, 0);
    chk("fin_stall", stall_cycles, 0);
    chk("fin_state_sticky", 32'(state), S_FINISHED);
    drive(0, 0, 0, 1);

    // Reset leaves FINISHED
    reset = 1'b0;
    #2;
    chk("rst_state", 32'(state), S_IDLE);
    chk("rst_ready_cnt", ready_cnt, 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_latency", latency_last, 0);
    @(posedge clock); #1 reset = 1'b1;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("post_rst_state", 32'(state), S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
